dp_tx_engine: RTL and testbench

Parametrised data-plane transmitter for a photonic-interconnect node. The GPP pushes messages (destination word followed by a fixed number of payload words) into a circular FIFO. When the control plane grants the data plane, the block serialises one message as a header packet plus payload packets. It replaces the fixed 16-bit, 4-word, stack-ordered transmitter with in-order buffering, a readiness output and pause-on-grant-loss.

---
 rtl/dp_pkg.sv | 22 ++
 rtl/dp_tx_fifo.sv | 84 ++++++++
 rtl/dp_tx_engine.sv | 144 ++++++++++++++
 tb/tb_dp_tx_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared data-plane definitions: FSM state encoding, default widths and the
// packet-width helper used by the transmitter and the receiver.
package dp_pkg;

    localparam int DP_DATA_W  = 16;
    localparam int DP_NODE_W  = 16;
    localparam int DP_DEPTH   = 16;
    localparam int DP_PAY_LEN = 4;
    localparam int PKT_W      = DP_DATA_W + DP_NODE_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAILER
    } dp_tx_state_e;

    function automatic int pkt_w(input int data_w, input int node_w);
        return data_w + node_w;
    endfunction

endpackage

// File: rtl/dp_tx_fifo.sv
// Circular word FIFO for the data-plane transmitter: combinational head,
// registered count/status, sticky overflow on a dropped push.
module dp_tx_fifo
    import dp_pkg::*;
#(
    parameter int DATA_W    = DP_DATA_W,
    parameter int DEPTH     = DP_DEPTH,
    parameter int READY_LVL = DP_PAY_LEN + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   ready,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              full_reg;
    logic              empty_reg;
    logic              ready_reg;
    logic              overflow_reg;
    logic              push_ok;
    logic              pop_ok;

    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign pop_ok  = pop && !empty_reg;
    assign push_ok = push && (!full_reg || pop_ok);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            ready_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
            ready_reg <= (count_next >= CNT_W'(READY_LVL));
            if (push && !push_ok) overflow_reg <= 1'b1;
        end
    end

    assign head     = mem[rd_ptr_reg];
    assign count    = count_reg;
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign ready    = ready_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/dp_tx_engine.sv
// Data-plane transmitter: buffers GPP messages and serialises header + payload
// packets while granted. Define DP_TX_CHECKSUM_EN to append an XOR trailer.
module dp_tx_engine
    import dp_pkg::*;
#(
    parameter int DATA_W  = DP_DATA_W,
    parameter int NODE_W  = DP_NODE_W,
    parameter int DEPTH   = DP_DEPTH,
    parameter int PAY_LEN = DP_PAY_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     gpp_wr_en,
    input  logic [DATA_W-1:0]        gpp_wr_data,
    input  logic [NODE_W-1:0]        node_id,
    input  logic                     data_tx_flag,
    output logic                     tx_ready,
    output logic [DATA_W+NODE_W-1:0] data_tx_packet,
    output logic                     data_tx_complete_flag,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     overflow
);

    localparam int PW     = pkt_w(DATA_W, NODE_W);
    localparam int BEAT_W = $clog2(PAY_LEN + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAY_LEN - 1);

    dp_tx_state_e      state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic [DATA_W-1:0] dest_reg, dest_next;
    logic [PW-1:0]     packet_reg, packet_next;
    logic              complete_reg, complete_next;
    logic              pop;
    logic [DATA_W-1:0] head_word;
`ifdef DP_TX_CHECKSUM_EN
    logic [DATA_W-1:0] sum_reg, sum_next;
`endif

    dp_tx_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .READY_LVL (PAY_LEN + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (gpp_wr_en),
        .push_data (gpp_wr_data),
        .pop       (pop),
        .head      (head_word),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ready     (tx_ready),
        .overflow  (overflow)
    );

    always_comb begin
        state_next    = state_reg;
        beat_next     = beat_reg;
        dest_next     = dest_reg;
        packet_next   = '0;
        complete_next = 1'b0;
        pop           = 1'b0;
`ifdef DP_TX_CHECKSUM_EN
        sum_next      = sum_reg;
`endif
        case (state_reg)
            // HEADER is folded into the launch: the header goes out the same
            // cycle the destination word is popped.
            ST_IDLE, ST_HEADER: begin
                state_next = ST_IDLE;
                if (data_tx_flag && tx_ready) begin
                    pop         = 1'b1;
                    dest_next   = head_word;
                    packet_next = {head_word, node_id};
                    beat_next   = '0;
                    state_next  = ST_PAYLOAD;
`ifdef DP_TX_CHECKSUM_EN
                    sum_next    = '0;
`endif
                end
            end
            ST_PAYLOAD: begin
                if (data_tx_flag) begin
                    pop         = 1'b1;
                    packet_next = {dest_reg, head_word};
`ifdef DP_TX_CHECKSUM_EN
                    sum_next    = sum_reg ^ head_word;
`endif
                    if (beat_reg == LAST_BEAT) begin
                        beat_next = '0;
`ifdef DP_TX_CHECKSUM_EN
                        state_next = ST_TRAILER;
`else
                        complete_next = 1'b1;
                        state_next    = ST_IDLE;
`endif
                    end else begin
                        beat_next = beat_reg + BEAT_W'(1);
                    end
                end
            end
            ST_TRAILER: begin
`ifdef DP_TX_CHECKSUM_EN
                if (data_tx_flag) begin
                    packet_next   = {dest_reg, sum_reg};
                    complete_next = 1'b1;
                    state_next    = ST_IDLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            beat_reg     <= '0;
            dest_reg     <= '0;
            packet_reg   <= '0;
            complete_reg <= 1'b0;
`ifdef DP_TX_CHECKSUM_EN
            sum_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            beat_reg     <= beat_next;
            dest_reg     <= dest_next;
            packet_reg   <= packet_next;
            complete_reg <= complete_next;
`ifdef DP_TX_CHECKSUM_EN
            sum_reg      <= sum_next;
`endif
        end
    end

    assign data_tx_packet        = packet_reg;
    assign data_tx_complete_flag = complete_reg;

endmodule

// File: tb/tb_dp_tx_engine.sv
// Directed bench for dp_tx_engine: in-order messages, readiness gating, pause,
// overflow/full corner, async reset mid-message; trailer checks if DP_TX_CHECKSUM_EN.
module tb_dp_tx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] node_id;
    logic        grant;
    logic        rdy;
    logic [31:0] pkt;
    logic        cmp;
    logic [4:0]  cnt;
    logic        full;
    logic        empty;
    logic        ovf;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

`ifdef DP_TX_CHECKSUM_EN
    localparam logic LAST_PAY_CMP = 1'b0;
`else
    localparam logic LAST_PAY_CMP = 1'b1;
`endif

    always #5 clk = ~clk;

    dp_tx_engine dut (
        .clk                   (clk),
        .rst                   (rst),
        .gpp_wr_en             (wr_en),
        .gpp_wr_data           (wr_data),
        .node_id               (node_id),
        .data_tx_flag          (grant),
        .tx_ready              (rdy),
        .data_tx_packet        (pkt),
        .data_tx_complete_flag (cmp),
        .fifo_count            (cnt),
        .fifo_full             (full),
        .fifo_empty            (empty),
        .overflow              (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] exp_pkt, input logic exp_cmp);
        tick();
        chk({tag, ".pkt"}, pkt, exp_pkt);
        chk({tag, ".cmp"}, cmp, exp_cmp);
    endtask

    task automatic run_payload(input string tag, input logic [15:0] dest, input logic [15:0] pay [4]);
        logic [15:0] x;
        x = '0;
        for (int i = 0; i < 4; i++) begin
            x ^= pay[i];
            beat($sformatf("%s.pay%0d", tag, i), {dest, pay[i]}, (i == 3) ? LAST_PAY_CMP : 1'b0);
        end
`ifdef DP_TX_CHECKSUM_EN
        beat({tag, ".trailer"}, {dest, x}, 1'b1);
`endif
    endtask

    task automatic run_msg(input string tag, input logic [15:0] dest, input logic [15:0] pay [4]);
        beat({tag, ".hdr"}, {dest, 16'h0002}, 1'b0);
        run_payload(tag, dest, pay);
    endtask

    initial begin
        logic [15:0] pay [4];
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        node_id = 16'h0002;
        grant   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.pkt", pkt, 32'h0);
        chk("rst.cmp", cmp, 1'b0);
        chk("rst.rdy", rdy, 1'b0);
        chk("rst.cnt", cnt, 5'd0);
        chk("rst.empty", empty, 1'b1);
        chk("rst.full", full, 1'b0);
        chk("rst.ovf", ovf, 1'b0);
        rst = 1'b1;
        tick();

        // Basic message with grant held
        push(16'h0005); push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        chk("t1.cnt", cnt, 5'd5);
        chk("t1.rdy", rdy, 1'b1);
        chk("t1.empty", empty, 1'b0);
        grant = 1'b1;
        pay = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_msg("t1", 16'h0005, pay);
        chk("t1.empty_after", empty, 1'b1);
        chk("t1.cnt_after", cnt, 5'd0);
        chk("t1.rdy_after", rdy, 1'b0);
        beat("t1.idle", 32'h0, 1'b0);

        // Grant without a full message buffered
        push(16'h0007); push(16'hA001); push(16'hA002); push(16'hA003);
        chk("t2.rdy4", rdy, 1'b0);
        beat("t2.wait0", 32'h0, 1'b0);
        beat("t2.wait1", 32'h0, 1'b0);
        chk("t2.cnt_held", cnt, 5'd4);
        push(16'hA004);
        chk("t2.pkt_on_push", pkt, 32'h0);
        chk("t2.rdy5", rdy, 1'b1);
        pay = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        run_msg("t2", 16'h0007, pay);
        grant = 1'b0;

        // Pause on grant loss mid-payload
        push(16'h0005); push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        grant = 1'b1;
        beat("t3.hdr", 32'h00050002, 1'b0);
        beat("t3.pay0", 32'h00051111, 1'b0);
        beat("t3.pay1", 32'h00052222, 1'b0);
        grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat($sformatf("t3.pause%0d", i), 32'h0, 1'b0);
            chk($sformatf("t3.pause%0d.cnt", i), cnt, 5'd2);
        end
        grant = 1'b1;
        pay = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        beat("t3.pay2", 32'h00053333, 1'b0);
        beat("t3.pay3", 32'h00054444, LAST_PAY_CMP);
`ifdef DP_TX_CHECKSUM_EN
        beat("t3.trailer", 32'h00054444, 1'b1);
`endif
        chk("t3.cnt_after", cnt, 5'd0);
        grant = 1'b0;

        // Fill, overflow, push+pop at full
        for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
        chk("t4.cnt16", cnt, 5'd16);
        chk("t4.full", full, 1'b1);
        chk("t4.rdy", rdy, 1'b1);
        chk("t4.ovf0", ovf, 1'b0);
        push(16'hDEAD);
        chk("t4.ovf1", ovf, 1'b1);
        chk("t4.cnt_ovf", cnt, 5'd16);
        wr_en   = 1'b1;
        wr_data = 16'hBEEF;
        grant   = 1'b1;
        beat("t4.m0.hdr", 32'h01000002, 1'b0);
        wr_en   = 1'b0;
        chk("t4.cnt_pushpop", cnt, 5'd16);
        chk("t4.full_pushpop", full, 1'b1);
        pay = '{16'h0101, 16'h0102, 16'h0103, 16'h0104};
        run_payload("t4.m0", 16'h0100, pay);
        pay = '{16'h0106, 16'h0107, 16'h0108, 16'h0109};
        run_msg("t4.m1", 16'h0105, pay);
        pay = '{16'h010B, 16'h010C, 16'h010D, 16'h010E};
        run_msg("t4.m2", 16'h010A, pay);
        grant = 1'b0;
        chk("t4.cnt_rem", cnt, 5'd2);
        chk("t4.rdy_rem", rdy, 1'b0);
        push(16'hC001); push(16'hC002); push(16'hC003);
        grant = 1'b1;
        pay = '{16'hBEEF, 16'hC001, 16'hC002, 16'hC003};
        run_msg("t4.m3", 16'h010F, pay);
        chk("t4.empty_end", empty, 1'b1);
        chk("t4.ovf_sticky", ovf, 1'b1);
        grant = 1'b0;

        // Asynchronous reset mid-payload
        push(16'h0009); push(16'h9001); push(16'h9002); push(16'h9003); push(16'h9004);
        grant = 1'b1;
        beat("t5.hdr", 32'h00090002, 1'b0);
        beat("t5.pay0", 32'h00099001, 1'b0);
        rst = 1'b0;
        #1;
        chk("t5.rst.pkt", pkt, 32'h0);
        chk("t5.rst.cmp", cmp, 1'b0);
        chk("t5.rst.cnt", cnt, 5'd0);
        chk("t5.rst.empty", empty, 1'b1);
        chk("t5.rst.rdy", rdy, 1'b0);
        chk("t5.rst.ovf", ovf, 1'b0);
        chk("t5.rst.full", full, 1'b0);
        grant = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        push(16'h000B); push(16'hB001); push(16'hB002); push(16'hB003); push(16'hB004);
        grant = 1'b1;
        pay = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};
        run_msg("t5.fresh", 16'h000B, pay);
        chk("t5.empty_end", empty, 1'b1);
        grant = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
